// File: rtl/sram_device_model_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_device_model_if
// Brief    : Control/address group of the asynchronous-SRAM bus.
// Revision : 1.0
// ============================================================================
interface sram_device_model_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );
endinterface
`default_nettype wire

// File: rtl/sram_device_model.sv
`default_nettype none
// ============================================================================
// Module   : sram_device_model
// Brief    : Clocked async-SRAM responder with read/write latency checking.
// Revision : 1.0
// ============================================================================
module sram_device_model #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 17,
    parameter int DEPTH         = 65536,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sram_device_model_if.slave     bus,
    inout  wire logic [DATA_W-1:0] SRAM_DQ,
    output logic                   wr_commit,
    output logic                   timing_err,
    output logic                   range_err
);
    localparam int               c_IDX_W  = $clog2(DEPTH);
    localparam int               c_HALF   = DATA_W / 2;
    localparam logic [ADDR_W:0]  c_DEPTH  = DEPTH[ADDR_W:0];
    localparam logic [3:0]       c_RD_LAT = READ_LATENCY[3:0];
    localparam logic [3:0]       c_WR_LAT = WRITE_LATENCY[3:0];

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_READ_WAIT  = 3'd1;
    localparam logic [2:0] S_READ_VALID = 3'd2;
    localparam logic [2:0] S_WRITE_WAIT = 3'd3;
    localparam logic [2:0] S_WRITE_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_rd;
    logic              w_wr;
    logic              w_same;
    logic              w_in_rd;
    logic              w_in_wr;
    logic              w_rd_new;
    logic              w_wr_new;
    logic              w_wr_cont;
    logic              w_addr_ok;
    logic              w_lat_ok;
    logic [3:0]        w_cnt_inc;
    logic [2:0]        w_cnt_sat;
    logic              w_commit;
    logic              w_abort;
    logic              w_drive;
    logic [DATA_W-1:0] w_rd_data;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_lat_idx;

    assign w_rd      = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    assign w_wr      = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    assign w_same    = (bus.SRAM_ADDR == r_lat_addr);
    assign w_in_rd   = (r_state == S_READ_WAIT) || (r_state == S_READ_VALID);
    assign w_in_wr   = (r_state == S_WRITE_WAIT) || (r_state == S_WRITE_DONE);
    assign w_rd_new  = w_rd && !(w_in_rd && w_same);
    assign w_wr_new  = w_wr && !(w_in_wr && w_same);
    assign w_wr_cont = w_wr && (r_state == S_WRITE_WAIT) && w_same;
    assign w_addr_ok = ({1'b0, bus.SRAM_ADDR} < c_DEPTH);
    assign w_lat_ok  = ({1'b0, r_lat_addr} < c_DEPTH);
    assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;
    assign w_cnt_sat = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
    assign w_wr_idx  = bus.SRAM_ADDR[c_IDX_W-1:0];
    assign w_lat_idx = r_lat_addr[c_IDX_W-1:0];

    // Commit address is the bus address: on a continuing write it equals lat_addr.
    assign w_commit = !rst && w_addr_ok &&
                      ((w_wr_new && (c_WR_LAT <= 4'd1)) ||
                       (w_wr_cont && (w_cnt_inc >= c_WR_LAT)));
    assign w_abort  = (r_state == S_WRITE_WAIT) && !w_wr_cont;

    assign w_drive   = (r_state == S_READ_VALID) && w_rd && w_same;
    assign w_rd_data = w_lat_ok ? r_mem[w_lat_idx] : '0;
    assign SRAM_DQ   = w_drive ? w_rd_data : 'z;

    // Array is deliberately outside the reset domain so it survives rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (!bus.SRAM_LB_N) r_mem[w_wr_idx][c_HALF-1:0]      <= SRAM_DQ[c_HALF-1:0];
            if (!bus.SRAM_UB_N) r_mem[w_wr_idx][DATA_W-1:c_HALF] <= SRAM_DQ[DATA_W-1:c_HALF];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_lat_addr <= '0;
            wr_commit  <= 1'b0;
            timing_err <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            wr_commit  <= w_commit;
            timing_err <= w_abort;
            range_err  <= (w_rd_new || w_wr_new) && !w_addr_ok;
            if (w_rd) begin
                if (w_rd_new) begin
                    r_lat_addr <= bus.SRAM_ADDR;
                    r_cnt      <= 3'd1;
                    r_state    <= (c_RD_LAT <= 4'd1) ? S_READ_VALID : S_READ_WAIT;
                end else begin
                    r_cnt <= w_cnt_sat;
                    if (w_cnt_inc >= c_RD_LAT) r_state <= S_READ_VALID;
                end
            end else if (w_wr) begin
                if (w_wr_new) begin
                    r_lat_addr <= bus.SRAM_ADDR;
                    r_cnt      <= 3'd1;
                    r_state    <= (c_WR_LAT <= 4'd1) ? S_WRITE_DONE : S_WRITE_WAIT;
                end else if (r_state == S_WRITE_WAIT) begin
                    r_cnt <= w_cnt_sat;
                    if (w_cnt_inc >= c_WR_LAT) r_state <= S_WRITE_DONE;
                end
            end else begin
                r_state <= S_IDLE;
                r_cnt   <= 3'd0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sram_device_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_device_model
// Brief    : Directed bench for sram_device_model; undriven DQ reads as all-ones.
// Revision : 1.0
// ============================================================================
module tb_sram_device_model;
    localparam logic [31:0] c_FLOAT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] r_tb_dq;
    logic        r_tb_oe;
    logic        wr_commit;
    logic        timing_err;
    logic        range_err;
    wire  [31:0] dq;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    sram_device_model_if #(.ADDR_W(17)) bus ();

    assign dq = r_tb_oe ? r_tb_dq : 'z;
    pullup (dq);

    sram_device_model #(
        .DATA_W(32), .ADDR_W(17), .DEPTH(65536), .READ_LATENCY(2), .WRITE_LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .SRAM_DQ    (dq),
        .wr_commit  (wr_commit),
        .timing_err (timing_err),
        .range_err  (range_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        bus.SRAM_CE_N = 1'b1; bus.SRAM_WE_N = 1'b1; bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b1; bus.SRAM_LB_N = 1'b1; r_tb_oe = 1'b0;
    endtask

    task automatic set_rd(input logic [16:0] addr);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0; bus.SRAM_WE_N = 1'b1; bus.SRAM_OE_N = 1'b0;
        bus.SRAM_UB_N = 1'b0; bus.SRAM_LB_N = 1'b0; r_tb_oe = 1'b0;
    endtask

    task automatic set_wr(input logic [16:0] addr, input logic [31:0] data,
                          input logic ub_n, input logic lb_n);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0; bus.SRAM_WE_N = 1'b0; bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
        r_tb_dq = data; r_tb_oe = 1'b1;
    endtask

    task automatic write_word(input logic [16:0] addr, input logic [31:0] data);
        set_wr(addr, data, 1'b0, 1'b0);
        tick(); tick();
        nop(); tick();
    endtask

    initial begin
        r_tb_dq = '0;
        nop();
        bus.SRAM_ADDR = '0;

        // Reset with a live read held on the bus
        rst = 1'b1;
        set_rd(17'd5);
        tick(); tick();
        chk("rst_dq_float", dq, c_FLOAT);
        chk("rst_wr_commit", {31'd0, wr_commit}, 32'd0);
        chk("rst_timing_err", {31'd0, timing_err}, 32'd0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        nop();
        tick();
        rst = 1'b0;
        tick();

        // Full write then read-back with latency 2
        set_wr(17'd5, 32'hCAFE_BABE, 1'b0, 1'b0);
        tick();
        chk("wr5_edge1_commit", {31'd0, wr_commit}, 32'd0);
        tick();
        chk("wr5_edge2_commit", {31'd0, wr_commit}, 32'd1);
        tick();
        chk("wr5_done_no_repulse", {31'd0, wr_commit}, 32'd0);
        nop(); tick();
        set_rd(17'd5);
        tick();
        chk("rd5_edge1_float", dq, c_FLOAT);
        tick();
        chk("rd5_edge2_data", dq, 32'hCAFE_BABE);
        nop(); tick();

        // Lower-lane-only write
        write_word(17'd7, 32'hAAAA_BBBB);
        set_wr(17'd7, 32'h1111_2222, 1'b1, 1'b0);
        tick(); tick();
        chk("wr7_lb_commit", {31'd0, wr_commit}, 32'd1);
        nop(); tick();
        set_rd(17'd7);
        tick(); tick();
        chk("rd7_masked", dq, 32'hAAAA_2222);
        nop(); tick();

        // Write aborted after one cycle
        write_word(17'd9, 32'h1234_5678);
        set_wr(17'd9, 32'hFFFF_0000, 1'b0, 1'b0);
        tick();
        chk("wr9_edge1_no_err", {31'd0, timing_err}, 32'd0);
        nop(); tick();
        chk("wr9_abort_timing_err", {31'd0, timing_err}, 32'd1);
        chk("wr9_abort_no_commit", {31'd0, wr_commit}, 32'd0);
        tick();
        chk("wr9_err_single_pulse", {31'd0, timing_err}, 32'd0);
        set_rd(17'd9);
        tick(); tick();
        chk("rd9_unchanged", dq, 32'h1234_5678);
        nop(); tick();

        // Read address change restarts latency
        write_word(17'd3, 32'h3333_3333);
        write_word(17'd4, 32'h4444_4444);
        set_rd(17'd3);
        tick();
        set_rd(17'd4);
        tick();
        chk("rd_restart_float", dq, c_FLOAT);
        chk("rd_restart_no_err", {31'd0, timing_err}, 32'd0);
        tick();
        chk("rd_restart_data4", dq, 32'h4444_4444);
        nop(); tick();

        // Out-of-range write must not alias onto word 0
        write_word(17'd0, 32'h5A5A_5A5A);
        set_wr(17'h10000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        chk("wr_oor_range_err", {31'd0, range_err}, 32'd1);
        chk("wr_oor_edge1_commit", {31'd0, wr_commit}, 32'd0);
        tick();
        chk("wr_oor_range_single", {31'd0, range_err}, 32'd0);
        chk("wr_oor_no_commit", {31'd0, wr_commit}, 32'd0);
        nop(); tick();
        set_rd(17'h10000);
        tick();
        chk("rd_oor_range_err", {31'd0, range_err}, 32'd1);
        tick();
        chk("rd_oor_zero", dq, 32'h0000_0000);
        nop(); tick();
        set_rd(17'd0);
        tick(); tick();
        chk("rd0_not_aliased", dq, 32'h5A5A_5A5A);
        nop(); tick();

        // Reset in the middle of a write loses it
        set_wr(17'd5, 32'h0BAD_F00D, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_wr_no_commit", {31'd0, wr_commit}, 32'd0);
        rst = 1'b0;
        nop(); tick();
        set_rd(17'd5);
        tick(); tick();
        chk("rd5_after_rst_kept", dq, 32'hCAFE_BABE);
        nop(); tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
